// File: rtl/booth_r16_pp_accum.sv
// ---------------------------------------------------------------------------
// booth_r16_pp_accum
//
// Sequential radix-16 Booth partial-product accumulator. A signed
// multiplicand is latched on start; one cycle later its odd multiples
// (1X, 3X, 5X, 7X) are registered. Each Booth digit arriving on the digit
// handshake selects one multiple, a shift of 0..3 and a sign. The resulting
// partial product is added into an accumulator that is shifted left by one
// digit (4 bits) per step, most significant digit first. After NDIG digits
// the signed 2*WIDTH product is presented until it is accepted.
//
// Ports:
//   iClk       clock, rising edge
//   iRstN      synchronous reset, active low
//   iStart     operation start, taken only while oStartRdy=1
//   oStartRdy  high in IDLE
//   iMcand     signed multiplicand, sampled on an accepted iStart
//   iDigVld    digit valid
//   oDigRdy    digit ready, high only in ACCUM
//   iNegative  digit sign
//   iBoothSel  one-hot multiple select [0]=1X [1]=3X [2]=5X [3]=7X, 0 = zero
//   iShiftSel  one-hot shift select, [k] = multiple << k
//   oPrdVld    product valid
//   iPrdRdy    product accept
//   oProduct   signed product, holds its value after it has been accepted
//   oErr       an illegal digit was seen in this operation (with oPrdVld)
// ---------------------------------------------------------------------------
module booth_r16_pp_accum #(
  parameter int WIDTH = 8,
  parameter int NDIG  = WIDTH / 4
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iStart,
  output logic                 oStartRdy,
  input  logic [WIDTH-1:0]     iMcand,
  input  logic                 iDigVld,
  output logic                 oDigRdy,
  input  logic                 iNegative,
  input  logic [3:0]           iBoothSel,
  input  logic [3:0]           iShiftSel,
  output logic                 oPrdVld,
  input  logic                 iPrdRdy,
  output logic [2*WIDTH-1:0]   oProduct,
  output logic                 oErr
);

  localparam int MW = WIDTH + 3;      // odd-multiple width (7X fits)
  localparam int PW = WIDTH + 7;      // partial-product width (7X << 3, negated)
  localparam int AW = 2 * WIDTH + 4;  // accumulator width
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         a_q, a_d;
  logic signed [MW-1:0]     m1_q, m1_d, m3_q, m3_d, m5_q, m5_d, m7_q, m7_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [2*WIDTH-1:0]       product_q, product_d;

  logic signed [MW-1:0]     a_ext;
  logic signed [MW-1:0]     msel;
  logic signed [PW-1:0]     msel_ext;
  logic signed [PW-1:0]     pp_mag;
  logic signed [PW-1:0]     pp;
  logic                     legal;
  logic                     dig_acc;

  assign oStartRdy = (state_q == S_IDLE);
  assign oDigRdy   = (state_q == S_ACCUM);
  assign oPrdVld   = (state_q == S_DONE);
  assign oProduct  = product_q;
  assign oErr      = err_q;

  assign dig_acc   = iDigVld && (state_q == S_ACCUM);

  // Digit legality: every encoding the Booth encoder can actually emit.
  // 1X may take any shift (1,2,4,8); 3X covers 3 and 6; 5X and 7X are
  // unshifted. Zero must be a positive, all-zero encoding.
  always_comb begin
    legal = 1'b0;
    case (iBoothSel)
      4'b0001: legal = (iShiftSel == 4'b0001) || (iShiftSel == 4'b0010) ||
                       (iShiftSel == 4'b0100) || (iShiftSel == 4'b1000);
      4'b0010: legal = (iShiftSel == 4'b0001) || (iShiftSel == 4'b0010);
      4'b0100: legal = (iShiftSel == 4'b0001);
      4'b1000: legal = (iShiftSel == 4'b0001);
      4'b0000: legal = (iShiftSel == 4'b0000) && !iNegative;
      default: legal = 1'b0;
    endcase
  end

  // Partial product: selected multiple, shifted, optionally negated.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    msel   = '0;
    pp_mag = '0;
    case (iBoothSel)
      4'b0001: msel = m1_q;
      4'b0010: msel = m3_q;
      4'b0100: msel = m5_q;
      4'b1000: msel = m7_q;
      default: msel = '0;
    endcase
    msel_ext = {{(PW-MW){msel[MW-1]}}, msel};
    case (iShiftSel)
      4'b0001: pp_mag = msel_ext;
      4'b0010: pp_mag = msel_ext <<< 1;
      4'b0100: pp_mag = msel_ext <<< 2;
      4'b1000: pp_mag = msel_ext <<< 3;
      default: pp_mag = '0;
    endcase
    if (!legal)        pp = '0;
    else if (iNegative) pp = -pp_mag;
    else               pp = pp_mag;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m1_d      = m1_q;
    m3_d      = m3_q;
    m5_d      = m5_q;
    m7_d      = m7_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    product_d = product_q;
    a_ext     = {{3{a_q[WIDTH-1]}}, a_q};

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          a_d     = iMcand;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        m1_d    = a_ext;
        m3_d    = a_ext + (a_ext <<< 1);
        m5_d    = a_ext + (a_ext <<< 2);
        m7_d    = (a_ext <<< 3) - a_ext;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (dig_acc) begin
          acc_d = (acc_q <<< 4) + {{(AW-PW){pp[PW-1]}}, pp};
          cnt_d = cnt_q + 1'b1;
          if (!legal) err_d = 1'b1;
          if (cnt_q == CW'(NDIG - 1)) begin
            // Capture here so oProduct is already valid in DONE and keeps
            // its value once the operation is over.
            product_d = acc_d[2*WIDTH-1:0];
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (iPrdRdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!iRstN) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m1_q      <= '0;
      m3_q      <= '0;
      m5_q      <= '0;
      m7_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m1_q      <= m1_d;
      m3_q      <= m3_d;
      m5_q      <= m5_d;
      m7_q      <= m7_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_r16_pp_accum.sv
// ---------------------------------------------------------------------------
// tb_booth_r16_pp_accum
//
// Directed bench for booth_r16_pp_accum (WIDTH=8, two digits per product).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the rising edge the DUT acts on.
// ---------------------------------------------------------------------------
module tb_booth_r16_pp_accum;

  localparam int WIDTH = 8;

  logic               clk;
  logic               iRstN;
  logic               iStart;
  logic               oStartRdy;
  logic [WIDTH-1:0]   iMcand;
  logic               iDigVld;
  logic               oDigRdy;
  logic               iNegative;
  logic [3:0]         iBoothSel;
  logic [3:0]         iShiftSel;
  logic               oPrdVld;
  logic               iPrdRdy;
  logic [2*WIDTH-1:0] oProduct;
  logic               oErr;

  int checks = 0;
  int errors = 0;

  booth_r16_pp_accum #(.WIDTH(WIDTH)) dut (
    .iClk      (clk),
    .iRstN     (iRstN),
    .iStart    (iStart),
    .oStartRdy (oStartRdy),
    .iMcand    (iMcand),
    .iDigVld   (iDigVld),
    .oDigRdy   (oDigRdy),
    .iNegative (iNegative),
    .iBoothSel (iBoothSel),
    .iShiftSel (iShiftSel),
    .oPrdVld   (oPrdVld),
    .iPrdRdy   (iPrdRdy),
    .oProduct  (oProduct),
    .oErr      (oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- stimulus helpers (drive only) ----------------------------------
  task automatic start_op(input logic [WIDTH-1:0] a);
    iStart = 1'b1;
    iMcand = a;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  // Present one digit and hold it until it has been accepted.
  task automatic send_digit(input logic neg, input logic [3:0] sel,
                            input logic [3:0] sh);
    int n;
    n = 0;
    iDigVld   = 1'b1;
    iNegative = neg;
    iBoothSel = sel;
    iShiftSel = sh;
    while (!oDigRdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!oDigRdy) begin
      checks++;
      errors++;
      $display("FAIL digit_timeout: oDigRdy=%0b required 1", oDigRdy);
    end
    @(negedge clk);
    iDigVld   = 1'b0;
    iNegative = 1'b0;
    iBoothSel = 4'b0000;
    iShiftSel = 4'b0000;
  endtask

  // Wait for the product, compare it and the error flag, then accept it.
  task automatic finish_op(input string name, input logic [15:0] exp_p,
                           input logic exp_err);
    int n;
    n = 0;
    while (!oPrdVld && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (oPrdVld !== 1'b1) begin
      errors++;
      $display("FAIL %s_vld: oPrdVld=%0b required 1", name, oPrdVld);
    end
    checks++;
    if (oProduct !== exp_p) begin
      errors++;
      $display("FAIL %s_product: got %h required %h", name, oProduct, exp_p);
    end
    checks++;
    if (oErr !== exp_err) begin
      errors++;
      $display("FAIL %s_err: got %0b required %0b", name, oErr, exp_err);
    end
    iPrdRdy = 1'b1;
    @(negedge clk);
    iPrdRdy = 1'b0;
    checks++;
    if (oStartRdy !== 1'b1 || oPrdVld !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: oStartRdy=%0b oPrdVld=%0b required 1/0",
               name, oStartRdy, oPrdVld);
    end
  endtask

  // ---- tests ------------------------------------------------------------
  task automatic test_reset();
    iRstN = 1'b0;
    repeat (2) @(negedge clk);
    iRstN = 1'b1;
    checks++;
    if ({oStartRdy, oPrdVld, oDigRdy, oErr} !== 4'b1000 || oProduct !== 16'h0000) begin
      errors++;
      $display("FAIL reset: rdy/vld/dig/err=%b product=%h required 1000/0000",
               {oStartRdy, oPrdVld, oDigRdy, oErr}, oProduct);
    end
  endtask

  // A=5, B=3 walked cycle by cycle to pin down the latency.
  task automatic test_basic_latency();
    iStart = 1'b1; iMcand = 8'd5;                   // cycle 0
    iDigVld = 1'b1; iNegative = 1'b0; iBoothSel = 4'b0000; iShiftSel = 4'b0000;
    @(negedge clk);                                 // cycle 1: LOAD
    iStart = 1'b0;
    checks++;
    if ({oStartRdy, oDigRdy, oPrdVld} !== 3'b000) begin
      errors++;
      $display("FAIL basic_load: rdy/dig/vld=%b required 000", {oStartRdy, oDigRdy, oPrdVld});
    end
    @(negedge clk);                                 // cycle 2: digit 0 taken
    checks++;
    if (oDigRdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_digrdy: got %0b required 1", oDigRdy);
    end
    @(negedge clk);                                 // cycle 3: digit +3 taken
    iBoothSel = 4'b0010; iShiftSel = 4'b0001;
    @(negedge clk);                                 // cycle 4: DONE
    iDigVld = 1'b0; iBoothSel = 4'b0000; iShiftSel = 4'b0000;
    checks++;
    if (oPrdVld !== 1'b1 || oProduct !== 16'h000F || oErr !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: vld=%0b product=%h err=%0b required 1/000f/0",
               oPrdVld, oProduct, oErr);
    end
    iPrdRdy = 1'b1;
    @(negedge clk);
    iPrdRdy = 1'b0;
    checks++;
    if (oStartRdy !== 1'b1 || oPrdVld !== 1'b0 || oProduct !== 16'h000F) begin
      errors++;
      $display("FAIL basic_retain: rdy=%0b vld=%0b product=%h required 1/0/000f",
               oStartRdy, oPrdVld, oProduct);
    end
  endtask

  task automatic test_patterns();
    // -128 * -128: digits -8 then 0
    start_op(8'h80);
    send_digit(1'b1, 4'b0001, 4'b1000);
    send_digit(1'b0, 4'b0000, 4'b0000);
    finish_op("m128sq", 16'h4000, 1'b0);
    // 127 * -1: digits 0 then -1
    start_op(8'h7F);
    send_digit(1'b0, 4'b0000, 4'b0000);
    send_digit(1'b1, 4'b0001, 4'b0001);
    finish_op("p127m1", 16'hFF81, 1'b0);
    // 100 * 100: digits +6 (3X<<1) then +4 (1X<<2) = 10000
    start_op(8'd100);
    send_digit(1'b0, 4'b0010, 4'b0010);
    send_digit(1'b0, 4'b0001, 4'b0100);
    finish_op("h100sq", 16'h2710, 1'b0);
    // -7 * -72: digits -5 (5X) then +8 (1X<<3) = 504
    start_op(8'hF9);
    send_digit(1'b1, 4'b0100, 4'b0001);
    send_digit(1'b0, 4'b0001, 4'b1000);
    finish_op("m7m72", 16'h01F8, 1'b0);
    // -3 * 7: digits 0 then +7 (7X) = -21
    start_op(8'hFD);
    send_digit(1'b0, 4'b0000, 4'b0000);
    send_digit(1'b0, 4'b1000, 4'b0001);
    finish_op("m3p7", 16'hFFEB, 1'b0);
  endtask

  task automatic test_back_to_back_stress();
    start_op(8'd5);
    iStart = 1'b1; iMcand = 8'd99;                  // stray start in LOAD/ACCUM
    send_digit(1'b0, 4'b0000, 4'b0000);             // valid 1
    repeat (2) @(negedge clk);                      // valid 0, 0
    send_digit(1'b0, 4'b0010, 4'b0001);             // valid 1
    for (int i = 0; i < 3; i++) begin               // iPrdRdy low 3 cycles
      checks++;
      if (oPrdVld !== 1'b1 || oProduct !== 16'h000F || oStartRdy !== 1'b0) begin
        errors++;
        $display("FAIL stress_hold%0d: vld=%0b product=%h rdy=%0b required 1/000f/0",
                 i, oPrdVld, oProduct, oStartRdy);
      end
      @(negedge clk);
    end
    iStart  = 1'b0;
    iPrdRdy = 1'b1;
    @(negedge clk);
    iPrdRdy = 1'b0;
    @(negedge clk);
    checks++;
    if (oStartRdy !== 1'b1 || oPrdVld !== 1'b0 || oProduct !== 16'h000F) begin
      errors++;
      $display("FAIL stress_idle: rdy=%0b vld=%0b product=%h required 1/0/000f",
               oStartRdy, oPrdVld, oProduct);
    end
  endtask

  task automatic test_illegal();
    // sel=0011 is illegal and contributes 0: 0*16 + 15 = 0x000F
    start_op(8'd5);
    send_digit(1'b0, 4'b0011, 4'b0001);
    send_digit(1'b0, 4'b0010, 4'b0001);
    finish_op("ill_sel", 16'h000F, 1'b1);
    // negative zero is illegal: +1 then -0 = 5*16 = 0x0050
    start_op(8'd5);
    send_digit(1'b0, 4'b0001, 4'b0001);
    send_digit(1'b1, 4'b0000, 4'b0000);
    finish_op("ill_negz", 16'h0050, 1'b1);
    // 3X<<2 is not an encodable digit either
    start_op(8'd5);
    send_digit(1'b0, 4'b0000, 4'b0000);
    send_digit(1'b0, 4'b0010, 4'b0100);
    finish_op("ill_shift", 16'h0000, 1'b1);
    // error flag starts clear on the next operation
    start_op(8'd5);
    send_digit(1'b0, 4'b0000, 4'b0000);
    send_digit(1'b0, 4'b0010, 4'b0001);
    finish_op("ill_clear", 16'h000F, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_op(8'd5);
    send_digit(1'b0, 4'b0001, 4'b0001);
    iRstN = 1'b0;
    @(negedge clk);
    iRstN = 1'b1;
    checks++;
    if ({oStartRdy, oDigRdy, oPrdVld, oErr} !== 4'b1000 || oProduct !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_state: rdy/dig/vld/err=%b product=%h required 1000/0000",
               {oStartRdy, oDigRdy, oPrdVld, oErr}, oProduct);
    end
    start_op(8'd5);
    send_digit(1'b0, 4'b0000, 4'b0000);
    send_digit(1'b0, 4'b0010, 4'b0001);
    finish_op("rstmid_op", 16'h000F, 1'b0);
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iMcand = '0; iDigVld = 1'b0;
    iNegative = 1'b0; iBoothSel = 4'b0000; iShiftSel = 4'b0000; iPrdRdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_latency();
    test_patterns();
    test_back_to_back_stress();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
